five_bit_serial_subtractor: RTL and testbench

Bit-serial 5-bit subtractor computing A − B one bit per clock, LSB first, with a start/done handshake. It is the reverse-direction counterpart of the parallel five-bit ripple adder. Game logic uses it to step snake coordinates and lengths downward, and to compare positions through the borrow and zero flags, without instantiating a second parallel adder chain. Results are registered and held until the next accepted start.

---
 rtl/five_bit_serial_subtractor.sv | 130 +++++++++++++
 tb/tb_five_bit_serial_subtractor.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/five_bit_serial_subtractor.sv
// five_bit_serial_subtractor
//   Bit-serial 5-bit unsigned subtractor (a - b mod 32), one bit per clock,
//   LSB first, with a start/done handshake. The result is registered and
//   held until the next accepted operation completes.
//
// Ports
//   clk     in   system clock, rising edge
//   rst_n   in   synchronous active-low reset
//   start   in   request; accepted only in IDLE
//   a       in   [4:0] minuend, sampled on the accepting edge
//   b       in   [4:0] subtrahend, sampled on the accepting edge
//   busy    out  high in SUB and DONE
//   done    out  one-cycle pulse when the result becomes valid
//   diff    out  [4:0] (a - b) mod 32
//   borrow  out  1 when a < b (unsigned)
//   zero    out  1 when diff == 0
module five_bit_serial_subtractor (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [4:0] a,
    input  logic [4:0] b,
    output logic       busy,
    output logic       done,
    output logic [4:0] diff,
    output logic       borrow,
    output logic       zero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] sa_q, sa_d;
    logic [4:0] sb_q, sb_d;
    logic [4:0] sd_q, sd_d;
    logic       br_q, br_d;
    logic [2:0] cnt_q, cnt_d;
    logic [4:0] diff_q, diff_d;
    logic       borrow_q, borrow_d;
    logic       zero_q, zero_d;

    // One full-subtractor bit-step on the current LSBs.
    logic       d_bit;
    logic       br_next;
    logic [4:0] sd_next;

    assign d_bit   = sa_q[0] ^ sb_q[0] ^ br_q;
    assign br_next = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
    // Result enters at the MSB so that after five steps bit 0 sits at SD[0].
    assign sd_next = {d_bit, sd_q[4:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            sd_q     <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            sd_q     <= sd_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        sd_d     = sd_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        zero_d   = zero_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_SUB;
                end
            end
            ST_SUB: begin
                sa_d  = {1'b0, sa_q[4:1]};
                sb_d  = {1'b0, sb_q[4:1]};
                sd_d  = sd_next;
                br_d  = br_next;
                cnt_d = cnt_q + 3'd1;
                // Outputs change only on the step that produces bit 4.
                if (cnt_q == 3'd4) begin
                    diff_d   = sd_next;
                    borrow_d = br_next;
                    zero_d   = (sd_next == '0);
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy   = (state_q == ST_SUB) || (state_q == ST_DONE);
    assign done   = (state_q == ST_DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_five_bit_serial_subtractor.sv
// tb_five_bit_serial_subtractor
//   Self-checking bench: directed cases, ignored-start and mid-operation
//   input changes, reset abort, randomized operations and an exhaustive
//   back-to-back sweep, all checked against plain unsigned arithmetic.
module tb_five_bit_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [4:0] a;
    logic [4:0] b;
    logic       busy;
    logic       done;
    logic [4:0] diff;
    logic       borrow;
    logic       zero;

    int n_vec;
    int n_err;
    int cyc;

    // Last completed result; outputs must hold this while an op is running.
    int prev_d;
    int prev_b;
    int prev_z;

    five_bit_serial_subtractor dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow),
        .zero   (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp_v);
        n_vec++;
        if (obs != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_diff"}, diff, 0);
        check({tag, "_borrow"}, borrow, 0);
        check({tag, "_zero"}, zero, 0);
    endtask

    // One operation from IDLE. Called at #1 after an edge with the DUT idle.
    // With poke set, start is pulsed with a=1,b=2 at edge N+2 and in DONE.
    task automatic run_op(input logic [4:0] ta, input logic [4:0] tb_v, input bit poke);
        int exp_d;
        int exp_b;
        int exp_z;
        int lat;
        exp_d = (int'(ta) - int'(tb_v)) & 31;
        exp_b = (ta < tb_v) ? 1 : 0;
        exp_z = (exp_d == 0) ? 1 : 0;

        a = ta;
        b = tb_v;
        start = 1'b1;
        @(posedge clk);            // accepting edge N
        #1;
        start = 1'b0;
        a = 5'($urandom);          // inputs free to change after accept
        b = 5'($urandom);
        check("busy_after_accept", busy, 1);

        lat = 0;
        while (lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
            check("busy_sub", busy, 1);
            check("hold_diff", diff, prev_d);
            check("hold_borrow", borrow, prev_b);
            check("hold_zero", zero, prev_z);
            if (poke && lat == 1) begin
                start = 1'b1;
                a = 5'd1;
                b = 5'd2;
            end else if (poke && lat == 2) begin
                start = 1'b0;
                a = 5'($urandom);
                b = 5'($urandom);
            end
        end
        check("latency", lat, 5);
        check("done_busy", busy, 1);
        check("diff", diff, exp_d);
        check("borrow", borrow, exp_b);
        check("zero", zero, exp_z);

        if (poke) begin
            start = 1'b1;
            a = 5'd1;
            b = 5'd2;
        end
        @(posedge clk);            // edge N+6, back to IDLE
        #1;
        start = 1'b0;
        check("done_pulse_end", done, 0);
        check("busy_end", busy, 0);
        check("diff_held", diff, exp_d);
        prev_d = exp_d;
        prev_b = exp_b;
        prev_z = exp_z;
    endtask

    initial begin
        int w;
        int last;
        n_vec  = 0;
        n_err  = 0;
        cyc    = 0;
        prev_d = 0;
        prev_b = 0;
        prev_z = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;

        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");

        // Reset wins over start on the same edge.
        start = 1'b1;
        a = 5'd13;
        b = 5'd5;
        @(posedge clk);
        #1;
        check_outputs_zero("rst_vs_start");
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases.
        run_op(5'd13, 5'd5, 1'b0);
        run_op(5'd5, 5'd13, 1'b0);
        run_op(5'd0, 5'd31, 1'b0);
        run_op(5'd31, 5'd0, 1'b0);
        run_op(5'd7, 5'd7, 1'b0);
        run_op(5'd0, 5'd0, 1'b0);
        run_op(5'd20, 5'd3, 1'b0);

        // Ignored start pulses in SUB and DONE; inputs change mid-SUB.
        run_op(5'd20, 5'd3, 1'b1);
        @(posedge clk);
        #1;
        check("no_queued_start", busy, 0);

        // Reset asserted for edge N+3 of an operation.
        a = 5'd17;
        b = 5'd3;
        start = 1'b1;
        @(posedge clk);            // N
        #1;
        start = 1'b0;
        @(posedge clk);            // N+1
        #1;
        @(posedge clk);            // N+2
        #1;
        rst_n = 1'b0;
        @(posedge clk);            // N+3
        #1;
        check_outputs_zero("rst_mid_sub");
        rst_n = 1'b1;
        prev_d = 0;
        prev_b = 0;
        prev_z = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            check("abort_no_done", done, 0);
            check("abort_idle", busy, 0);
        end
        run_op(5'd9, 5'd4, 1'b0);

        // Randomized operations.
        for (int k = 0; k < 150; k++) begin
            run_op(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                   1'($urandom_range(0, 1)));
        end

        // Exhaustive sweep with start held high (back-to-back).
        start = 1'b1;
        last = 0;
        for (int i = 0; i < 1024; i++) begin
            int ea;
            int eb;
            ea = i >> 5;
            eb = i & 31;
            a = 5'(ea);
            b = 5'(eb);
            w = 0;
            do begin
                @(posedge clk);
                #1;
                w++;
            end while (!done && w < 20);
            check("exh_done_seen", done, 1);
            if (i > 0) check("exh_spacing", cyc - last, 7);
            last = cyc;
            check("exh_diff", diff, (ea - eb) & 31);
            check("exh_borrow", borrow, (ea < eb) ? 1 : 0);
            check("exh_zero", zero, (((ea - eb) & 31) == 0) ? 1 : 0);
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        check("exh_final_done", done, 0);
        @(posedge clk);
        #1;
        check("exh_final_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
